// File: rtl/watchdog_escalator_pkg.sv
// Shared types and default constants for the watchdog escalation path.
package watchdog_escalator_pkg;

  // Width of the encoded FSM state, also exposed on the debug port.
  localparam int STATE_W = 2;

  // Default tuning: grace window in WARN and the length of the forced reset pulse.
  localparam int DEFAULT_GRACE_CYCLES = 8;
  localparam int DEFAULT_RST_CYCLES   = 4;
  localparam int DEFAULT_CNT_W        = 8;
  localparam int DEFAULT_RC_W         = 4;

  // Escalation states; the encoding is visible on the debug port.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    WARN  = 2'd2,
    RESET = 2'd3
  } esc_state_t;

endpackage

// File: rtl/watchdog_escalator_down_counter.sv
// Shared down-counter for the WARN grace window and the RESET pulse length.
// Load has priority over decrement; the count stops at zero.
module esc_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load, or count down while non-zero; cleared by synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/watchdog_escalator.sv
// Two-step escalation of a watchdog timeout: warning interrupt with a grace
// window, then a fixed-length system reset pulse. Also drives the timer's
// heartbeat so it restarts after a kick, an acknowledge or a forced reset.
module watchdog_escalator
  import watchdog_escalator_pkg::*;
#(
  parameter int GRACE_CYCLES = DEFAULT_GRACE_CYCLES,
  parameter int RST_CYCLES   = DEFAULT_RST_CYCLES,
  parameter int CNT_W        = DEFAULT_CNT_W,
  parameter int RC_W         = DEFAULT_RC_W
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_timeout,
  input  logic            i_kick,
  output logic            heartbeat,
  output logic            irq,
  output logic            sys_rstn,
  output logic [RC_W-1:0] reset_count,
  output logic [1:0]      state
);

  // Reject parameter sets the down-counter cannot represent.
  if (GRACE_CYCLES < 1 || GRACE_CYCLES >= (1 << CNT_W)) begin : g_bad_grace
    $error("GRACE_CYCLES must be in 1..2**CNT_W-1");
  end
  if (RST_CYCLES < 1 || RST_CYCLES >= (1 << CNT_W)) begin : g_bad_rst
    $error("RST_CYCLES must be in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_MAX     = '1;

  esc_state_t       r_state;
  esc_state_t       w_next_state;
  logic             r_heartbeat;
  logic             r_irq;
  logic             r_sys_rstn;
  logic [RC_W-1:0]  r_reset_count;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_zero;
  logic             w_escalate;

  esc_down_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Next-state and counter control; kick beats timeout in IDLE and beats escalation in WARN.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_dec        = 1'b0;
    w_escalate   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_kick) begin
          w_next_state = CLEAR;
        end else if (i_timeout) begin
          w_next_state = WARN;
          w_load       = 1'b1;
          w_load_val   = GRACE_LOAD;
        end
      end
      CLEAR: begin
        w_next_state = IDLE;
      end
      WARN: begin
        if (i_kick) begin
          w_next_state = CLEAR;
        end else if (w_zero) begin
          w_next_state = RESET;
          w_load       = 1'b1;
          w_load_val   = RST_LOAD;
          w_escalate   = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      RESET: begin
        if (w_zero) begin
          w_next_state = IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register with outputs registered from the next state, so they always match r_state.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state       <= IDLE;
      r_heartbeat   <= 1'b0;
      r_irq         <= 1'b0;
      r_sys_rstn    <= 1'b1;
      r_reset_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_heartbeat <= (w_next_state == CLEAR) || (w_next_state == RESET);
      r_irq       <= (w_next_state == WARN);
      r_sys_rstn  <= (w_next_state != RESET);
      if (w_escalate && (r_reset_count != RC_MAX)) begin
        r_reset_count <= r_reset_count + RC_W'(1);
      end
    end
  end

  assign heartbeat   = r_heartbeat;
  assign irq         = r_irq;
  assign sys_rstn    = r_sys_rstn;
  assign reset_count = r_reset_count;
  assign state       = r_state;

endmodule

// File: tb/tb_watchdog_escalator.sv
// Directed bench for watchdog_escalator with GRACE=8, RST=4, RC_W=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_watchdog_escalator;

  localparam int GRACE = 8;
  localparam int RSTC  = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_WARN  = 2'd2;
  localparam logic [1:0] S_RESET = 2'd3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       timeout;
  logic       kick;
  logic       heartbeat;
  logic       irq;
  logic       sys_rstn;
  logic [3:0] reset_count;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  watchdog_escalator #(
    .GRACE_CYCLES (GRACE),
    .RST_CYCLES   (RSTC),
    .CNT_W        (8),
    .RC_W         (4)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_timeout   (timeout),
    .i_kick      (kick),
    .heartbeat   (heartbeat),
    .irq         (irq),
    .sys_rstn    (sys_rstn),
    .reset_count (reset_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against its expected value.
  task automatic expect_out(input string tag, input logic [1:0] e_state, input logic e_hb,
                            input logic e_irq, input logic e_rstn, input logic [3:0] e_rc);
    checks++;
    assert (state === e_state) else begin
      failures++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, e_state);
    end
    checks++;
    assert (heartbeat === e_hb) else begin
      failures++;
      $error("FAIL %s heartbeat observed=%0b expected=%0b", tag, heartbeat, e_hb);
    end
    checks++;
    assert (irq === e_irq) else begin
      failures++;
      $error("FAIL %s irq observed=%0b expected=%0b", tag, irq, e_irq);
    end
    checks++;
    assert (sys_rstn === e_rstn) else begin
      failures++;
      $error("FAIL %s sys_rstn observed=%0b expected=%0b", tag, sys_rstn, e_rstn);
    end
    checks++;
    assert (reset_count === e_rc) else begin
      failures++;
      $error("FAIL %s reset_count observed=%0d expected=%0d", tag, reset_count, e_rc);
    end
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    logic [3:0] exp_rc;

    rstn    = 1'b0;
    timeout = 1'b0;
    kick    = 1'b0;

    // Reset
    step();
    step();
    expect_out("reset", S_IDLE, 1'b0, 1'b0, 1'b1, 4'd0);
    rstn = 1'b1;

    // Quiet idle
    for (int i = 0; i < 20; i++) begin
      step();
      expect_out("idle_quiet", S_IDLE, 1'b0, 1'b0, 1'b1, 4'd0);
    end
    $display("txn idle_quiet done");

    // Kick in IDLE: one heartbeat cycle
    kick = 1'b1;
    step();
    expect_out("kick_clear", S_CLEAR, 1'b1, 1'b0, 1'b1, 4'd0);
    kick = 1'b0;
    step();
    expect_out("kick_back_idle", S_IDLE, 1'b0, 1'b0, 1'b1, 4'd0);
    $display("txn idle_kick done");

    // Timeout then acknowledge on the 5th edge
    timeout = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("ack_warn", S_WARN, 1'b0, 1'b1, 1'b1, 4'd0);
    end
    kick = 1'b1;
    step();
    expect_out("ack_clear", S_CLEAR, 1'b1, 1'b0, 1'b1, 4'd0);
    kick    = 1'b0;
    timeout = 1'b0;
    step();
    expect_out("ack_idle", S_IDLE, 1'b0, 1'b0, 1'b1, 4'd0);
    $display("txn warn_ack done");

    // Full escalation: 8 WARN cycles, 4 RESET cycles
    timeout = 1'b1;
    for (int i = 0; i < GRACE; i++) begin
      step();
      expect_out("esc_warn", S_WARN, 1'b0, 1'b1, 1'b1, 4'd0);
    end
    for (int i = 0; i < RSTC; i++) begin
      step();
      timeout = 1'b0;
      expect_out("esc_reset", S_RESET, 1'b1, 1'b0, 1'b0, 4'd1);
    end
    step();
    expect_out("esc_idle", S_IDLE, 1'b0, 1'b0, 1'b1, 4'd1);
    $display("txn escalation done");

    // Kick on the last WARN cycle wins over escalation
    timeout = 1'b1;
    for (int i = 0; i < GRACE; i++) begin
      step();
      expect_out("late_warn", S_WARN, 1'b0, 1'b1, 1'b1, 4'd1);
    end
    kick = 1'b1;
    step();
    expect_out("late_clear", S_CLEAR, 1'b1, 1'b0, 1'b1, 4'd1);
    kick    = 1'b0;
    timeout = 1'b0;
    step();
    expect_out("late_idle", S_IDLE, 1'b0, 1'b0, 1'b1, 4'd1);
    $display("txn late_kick done");

    // Reset asserted in the middle of a RESET pulse
    timeout = 1'b1;
    for (int i = 0; i < GRACE; i++) begin
      step();
      expect_out("mid_warn", S_WARN, 1'b0, 1'b1, 1'b1, 4'd1);
    end
    step();
    timeout = 1'b0;
    expect_out("mid_reset1", S_RESET, 1'b1, 1'b0, 1'b0, 4'd2);
    step();
    expect_out("mid_reset2", S_RESET, 1'b1, 1'b0, 1'b0, 4'd2);
    rstn = 1'b0;
    step();
    expect_out("mid_rst_applied", S_IDLE, 1'b0, 1'b0, 1'b1, 4'd0);
    rstn = 1'b1;
    step();
    expect_out("mid_rst_idle", S_IDLE, 1'b0, 1'b0, 1'b1, 4'd0);
    $display("txn reset_mid_pulse done");

    // 20 escalations: reset_count saturates at 15
    exp_rc = 4'd0;
    for (int n = 1; n <= 20; n++) begin
      if (exp_rc != 4'd15) exp_rc = exp_rc + 4'd1;
      timeout = 1'b1;
      for (int i = 0; i < GRACE; i++) step();
      expect_out("sat_last_warn", S_WARN, 1'b0, 1'b1, 1'b1, (n <= 16) ? 4'(n - 1) : 4'd15);
      step();
      timeout = 1'b0;
      expect_out("sat_reset", S_RESET, 1'b1, 1'b0, 1'b0, exp_rc);
      for (int i = 1; i < RSTC; i++) step();
      step();
      expect_out("sat_idle", S_IDLE, 1'b0, 1'b0, 1'b1, exp_rc);
      $display("txn saturation n=%0d reset_count=%0d", n, reset_count);
    end

    // Kick and timeout together in IDLE: kick wins
    kick    = 1'b1;
    timeout = 1'b1;
    step();
    expect_out("both_clear", S_CLEAR, 1'b1, 1'b0, 1'b1, 4'd15);
    kick    = 1'b0;
    timeout = 1'b0;
    step();
    expect_out("both_idle", S_IDLE, 1'b0, 1'b0, 1'b1, 4'd15);
    $display("txn kick_and_timeout done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
